// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard controller: FSM states, forward selects
// and the per-operand forwarding priority function.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // Youngest producer wins; x0 is hardwired zero and never forwarded.
  function automatic logic [1:0] fwd_pick(
    input logic [4:0] rs,
    input logic       exmem_we,
    input logic [4:0] exmem_rd,
    input logic       memwb_we,
    input logic [4:0] memwb_rd
  );
    if (exmem_we && (exmem_rd != 5'd0) && (exmem_rd == rs))      return FWD_EXMEM;
    else if (memwb_we && (memwb_rd != 5'd0) && (memwb_rd == rs)) return FWD_MEMWB;
    else                                                         return FWD_RF;
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational EX-stage operand forwarding, one select per source operand.
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] idex_rs1,
  input  logic [4:0] idex_rs2,
  input  logic [4:0] exmem_rd,
  input  logic       exmem_reg_write,
  input  logic [4:0] memwb_rd,
  input  logic       memwb_reg_write,
  output logic [1:0] forward_a,
  output logic [1:0] forward_b
);

  assign forward_a = fwd_pick(idex_rs1, exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd);
  assign forward_b = fwd_pick(idex_rs2, exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd);

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall / taken-branch flush controller with forwarding and
// saturating stall/flush event counters. State moves on the falling clock edge.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       idex_rs1,
  input  logic [4:0]       idex_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_mem_read,
  input  logic [4:0]       exmem_rd,
  input  logic             exmem_reg_write,
  input  logic [4:0]       memwb_rd,
  input  logic             memwb_reg_write,
  input  logic             branch_taken,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

  state_e           state_q, state_d;
  logic [2:0]       stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic             luh;

  forward_unit u_fwd (
    .idex_rs1       (idex_rs1),
    .idex_rs2       (idex_rs2),
    .exmem_rd       (exmem_rd),
    .exmem_reg_write(exmem_reg_write),
    .memwb_rd       (memwb_rd),
    .memwb_reg_write(memwb_reg_write),
    .forward_a      (forward_a),
    .forward_b      (forward_b)
  );

  assign luh = idex_mem_read && (idex_rd != 5'd0) &&
               ((idex_rd == id_rs1) || (idex_rd == id_rs2));

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      stall_cnt_q   <= 3'd0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      stall_cnt_q   <= stall_cnt_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (branch_taken) begin
          state_d = ST_FLUSH;
        end else if (luh) begin
          stall_cnt_d = STALL_RELOAD;
          state_d     = (STALL_RELOAD != 3'd0) ? ST_STALL : ST_RUN;
        end
      end
      ST_STALL: begin
        if (branch_taken) begin
          state_d     = ST_FLUSH;
          stall_cnt_d = 3'd0;
        end else begin
          stall_cnt_d = stall_cnt_q - 3'd1;
          if (stall_cnt_q == 3'd1) state_d = ST_RUN;
        end
      end
      // Load-use is masked here: IF/ID holds the branch target fetch.
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    flush       = 1'b0;
    case (state_q)
      ST_RUN, ST_STALL: begin
        if (branch_taken) begin
          flush = 1'b1;
        end else if (luh || (state_q == ST_STALL)) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (idex_bubble && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);
    if (flush && (flush_count_q != '1))       flush_count_d = flush_count_q + CNT_W'(1);
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench: two controllers (LOAD_STALL_CYCLES=1/CNT_W=4 and
// LOAD_STALL_CYCLES=3/CNT_W=32) driven on rising edges, checked before the falling edge.
module tb_hazard_ctrl;

  typedef struct packed {
    logic [4:0] id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd;
    logic       idex_mem_read;
    logic [4:0] exmem_rd;
    logic       exmem_reg_write;
    logic [4:0] memwb_rd;
    logic       memwb_reg_write;
    logic       branch_taken;
  } hin_t;

  typedef struct {
    bit          sel;
    string       tag;
    logic        pcw, ifw, bub, fl;
    logic [1:0]  fa, fb;
    logic [31:0] sc, fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  hin_t inA = '0, inB = '0;

  logic [1:0]  a_fa, a_fb, b_fa, b_fb;
  logic        a_pcw, a_ifw, a_bub, a_fl, b_pcw, b_ifw, b_bub, b_fl;
  logic [3:0]  a_sc, a_fc;
  logic [31:0] b_sc, b_fc;

  exp_t sb[$];
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(inA.id_rs1), .id_rs2(inA.id_rs2), .idex_rs1(inA.idex_rs1), .idex_rs2(inA.idex_rs2),
    .idex_rd(inA.idex_rd), .idex_mem_read(inA.idex_mem_read),
    .exmem_rd(inA.exmem_rd), .exmem_reg_write(inA.exmem_reg_write),
    .memwb_rd(inA.memwb_rd), .memwb_reg_write(inA.memwb_reg_write),
    .branch_taken(inA.branch_taken),
    .forward_a(a_fa), .forward_b(a_fb), .pc_write(a_pcw), .ifid_write(a_ifw),
    .idex_bubble(a_bub), .flush(a_fl), .stall_count(a_sc), .flush_count(a_fc)
  );

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(32)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(inB.id_rs1), .id_rs2(inB.id_rs2), .idex_rs1(inB.idex_rs1), .idex_rs2(inB.idex_rs2),
    .idex_rd(inB.idex_rd), .idex_mem_read(inB.idex_mem_read),
    .exmem_rd(inB.exmem_rd), .exmem_reg_write(inB.exmem_reg_write),
    .memwb_rd(inB.memwb_rd), .memwb_reg_write(inB.memwb_reg_write),
    .branch_taken(inB.branch_taken),
    .forward_a(b_fa), .forward_b(b_fb), .pc_write(b_pcw), .ifid_write(b_ifw),
    .idex_bubble(b_bub), .flush(b_fl), .stall_count(b_sc), .flush_count(b_fc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input bit sel, input string tag,
                              input logic pcw, input logic ifw, input logic bub, input logic fl,
                              input logic [1:0] fa, input logic [1:0] fb,
                              input int sc, input int fc);
    exp_t e;
    e.sel = sel; e.tag = tag; e.pcw = pcw; e.ifw = ifw; e.bub = bub; e.fl = fl;
    e.fa = fa; e.fb = fb; e.sc = 32'(sc); e.fc = 32'(fc);
    return e;
  endfunction

  // Expected outputs for plain RUN / for a bubble cycle / for a flush cycle
  function automatic exp_t run_e(input bit sel, input string tag, input int sc, input int fc);
    return mk(sel, tag, 1, 1, 0, 0, 2'b00, 2'b00, sc, fc);
  endfunction
  function automatic exp_t bub_e(input bit sel, input string tag, input int sc, input int fc);
    return mk(sel, tag, 0, 0, 1, 0, 2'b00, 2'b00, sc, fc);
  endfunction
  function automatic exp_t fl_e(input bit sel, input string tag, input int sc, input int fc);
    return mk(sel, tag, 1, 1, 0, 1, 2'b00, 2'b00, sc, fc);
  endfunction

  function automatic hin_t luh_in(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    hin_t h = '0;
    h.idex_mem_read = 1'b1; h.idex_rd = rd; h.id_rs1 = rs1; h.id_rs2 = rs2;
    return h;
  endfunction

  function automatic hin_t br_in();
    hin_t h = '0;
    h.branch_taken = 1'b1;
    return h;
  endfunction

  task automatic drain();
    exp_t e;
    logic [1:0] ofa, ofb;
    logic opcw, oifw, obub, ofl;
    logic [31:0] osc, ofc;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sel) begin
        ofa = b_fa; ofb = b_fb; opcw = b_pcw; oifw = b_ifw; obub = b_bub; ofl = b_fl;
        osc = b_sc; ofc = b_fc;
      end else begin
        ofa = a_fa; ofb = a_fb; opcw = a_pcw; oifw = a_ifw; obub = a_bub; ofl = a_fl;
        osc = 32'(a_sc); ofc = 32'(a_fc);
      end
      chk({e.tag, ".pc_write"},    32'(opcw), 32'(e.pcw));
      chk({e.tag, ".ifid_write"},  32'(oifw), 32'(e.ifw));
      chk({e.tag, ".idex_bubble"}, 32'(obub), 32'(e.bub));
      chk({e.tag, ".flush"},       32'(ofl),  32'(e.fl));
      chk({e.tag, ".forward_a"},   32'(ofa),  32'(e.fa));
      chk({e.tag, ".forward_b"},   32'(ofb),  32'(e.fb));
      chk({e.tag, ".stall_count"}, osc, e.sc);
      chk({e.tag, ".flush_count"}, ofc, e.fc);
    end
  endtask

  task automatic step(input bit sel, input hin_t h, input exp_t e);
    @(posedge clk);
    if (sel) inB = h; else inA = h;
    sb.push_back(e);
    #1 drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hin_t h;
    #2;
    sb.push_back(run_e(0, "rst_a", 0, 0));
    sb.push_back(run_e(1, "rst_b", 0, 0));
    drain();
    @(posedge clk);
    rst_n = 1'b1;

    // Forwarding priority and x0 exclusion
    h = '0; h.idex_rs2 = 7; h.exmem_rd = 7; h.exmem_reg_write = 1; h.memwb_rd = 7; h.memwb_reg_write = 1;
    step(0, h, mk(0, "fwd_both", 1, 1, 0, 0, 2'b00, 2'b10, 0, 0));
    h.exmem_rd = 0; h.memwb_rd = 0;
    step(0, h, mk(0, "fwd_x0", 1, 1, 0, 0, 2'b00, 2'b00, 0, 0));
    h = '0; h.idex_rs1 = 7; h.idex_rs2 = 7; h.exmem_rd = 7; h.memwb_rd = 7; h.memwb_reg_write = 1;
    step(0, h, mk(0, "fwd_exmem_nowe", 1, 1, 0, 0, 2'b01, 2'b01, 0, 0));
    h = '0; h.idex_rs1 = 3; h.idex_rs2 = 9; h.exmem_rd = 3; h.exmem_reg_write = 1; h.memwb_rd = 9; h.memwb_reg_write = 1;
    step(0, h, mk(0, "fwd_split", 1, 1, 0, 0, 2'b10, 2'b01, 0, 0));

    // Load-use with one bubble, then the consumer takes MEM/WB forward
    step(0, luh_in(5, 5, 0), bub_e(0, "lu_stall", 0, 0));
    h = '0; h.exmem_rd = 5; h.exmem_reg_write = 1;
    step(0, h, run_e(0, "lu_resume", 1, 0));
    h = '0; h.idex_rs1 = 5; h.memwb_rd = 5; h.memwb_reg_write = 1;
    step(0, h, mk(0, "lu_fwd", 1, 1, 0, 0, 2'b01, 2'b00, 1, 0));
    step(0, luh_in(0, 0, 0), run_e(0, "lu_x0", 1, 0));

    // 20 back-to-back load-use stalls on rs2; 4-bit counter saturates at 15
    for (int k = 0; k < 20; k++)
      step(0, luh_in(6, 1, 6), bub_e(0, $sformatf("sat%0d", k), (k + 1 > 15) ? 15 : k + 1, 0));
    step(0, '0, run_e(0, "sat_hold", 15, 0));

    // Taken branch in RUN; FLUSH masks load-use; back to RUN
    step(0, br_in(), fl_e(0, "br_flush", 15, 0));
    step(0, luh_in(5, 5, 0), run_e(0, "br_flushst", 15, 1));
    step(0, luh_in(5, 5, 0), bub_e(0, "br_run", 15, 1));
    step(0, '0, run_e(0, "br_idle", 15, 1));
    inA = '0;

    // LOAD_STALL_CYCLES=3, branch in second STALL cycle cuts the stall
    step(1, luh_in(4, 0, 4), bub_e(1, "s3_run", 0, 0));
    step(1, '0, bub_e(1, "s3_st1", 1, 0));
    step(1, br_in(), fl_e(1, "s3_br", 2, 0));
    step(1, '0, run_e(1, "s3_flushst", 2, 1));
    step(1, '0, run_e(1, "s3_run2", 2, 1));

    // Simultaneous branch and load-use: flush only
    h = luh_in(4, 4, 0); h.branch_taken = 1'b1;
    step(1, h, fl_e(1, "sim_br", 2, 1));
    step(1, '0, run_e(1, "sim_flushst", 2, 2));
    step(1, '0, run_e(1, "sim_run", 2, 2));

    // Uninterrupted 3-cycle stall
    step(1, luh_in(8, 0, 8), bub_e(1, "full0", 2, 2));
    step(1, '0, bub_e(1, "full1", 3, 2));
    step(1, '0, bub_e(1, "full2", 4, 2));
    step(1, '0, run_e(1, "full_end", 5, 2));

    // Asynchronous reset in the middle of a stall
    step(1, luh_in(8, 8, 0), bub_e(1, "rst_st0", 5, 2));
    step(1, '0, bub_e(1, "rst_st1", 6, 2));
    #1 rst_n = 1'b0;
    #1;
    sb.push_back(run_e(1, "rst_async_b", 0, 0));
    sb.push_back(run_e(0, "rst_async_a", 0, 0));
    drain();
    @(posedge clk);
    rst_n = 1'b1;
    step(1, '0, run_e(1, "rst_rel", 0, 0));
    step(1, luh_in(8, 8, 0), bub_e(1, "rst_rel_luh", 0, 0));
    step(1, '0, bub_e(1, "rst_rel_st", 1, 0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
